// File: rtl/fmdll_pkg.sv
// Shared types for the frequency-measure / lock-detect blocks.
// Latency: n/a (types only).
// Backpressure: n/a.
package fmdll_pkg;

    // Lock-detector state encoding shared by the FSM and anything observing it.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACQ    = 2'd1,
        ST_LOCKED = 2'd2
    } lock_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous control bit.
// Latency: 2 clk cycles from i_d to o_q.
// Backpressure: none (free-running).
//
// Ports: clk, rst_n (async active-low), i_d (async input), o_q (synchronized output).
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/div_lock_det.sv
// Measures the period of a divided clock in clk cycles and declares frequency lock.
// Latency: 2 clk cycles from a div_in rising edge at the input register to period/err/locked
//          (+2 more when DIV_LOCK_DET_SYNC_EN is defined).
// Backpressure: none; period_vld/err are single-cycle pulses with no handshake.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   div_in          divided clock under test
//   period          last measured period (holds between measurements)
//   period_vld      one-cycle pulse when period updates
//   locked          high while LOCK_CNT consecutive periods matched and none failed since
//   err             one-cycle pulse on a mismatching period or on a missing-edge timeout
// Build option: define DIV_LOCK_DET_SYNC_EN when div_in is asynchronous to clk.
module div_lock_det
    import fmdll_pkg::*;
#(
    parameter int DIV_RATIO = 4,
    parameter int LOCK_CNT  = 8,
    parameter int TOL       = 0,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             div_in,
    output logic [CNT_W-1:0] period,
    output logic             period_vld,
    output logic             locked,
    output logic             err
);

    localparam int MC_W = $clog2(LOCK_CNT + 1);

    localparam logic [CNT_W:0]   RATIO_X  = (CNT_W+1)'(DIV_RATIO);
    localparam logic [CNT_W:0]   TOL_X    = (CNT_W+1)'(TOL);
    // Timeout is taken on the cycle whose update would make elapsed reach the threshold,
    // so an edge in that very cycle still counts as an edge.
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(2 * DIV_RATIO + TOL - 1);
    localparam logic [MC_W-1:0]  LOCK_TGT = MC_W'(LOCK_CNT);

    // ------------------------------------------------------------------
    // Input capture and edge detect
    // ------------------------------------------------------------------
    logic w_div_src;

`ifdef DIV_LOCK_DET_SYNC_EN
    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (div_in),
        .o_q   (w_div_src)
    );
`else
    assign w_div_src = div_in;
`endif

    logic r_div_s;
    logic r_div_prev;
    logic w_edge;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_s    <= 1'b0;
            r_div_prev <= 1'b0;
        end else begin
            r_div_s    <= w_div_src;
            r_div_prev <= r_div_s;
        end
    end

    assign w_edge = r_div_s & ~r_div_prev;

    // ------------------------------------------------------------------
    // Elapsed counter: cycles since the last edge cycle, saturating
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] r_elapsed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_elapsed <= '0;
        end else if (w_edge) begin
            r_elapsed <= '0;
        end else if (r_elapsed != {CNT_W{1'b1}}) begin
            r_elapsed <= r_elapsed + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Measurement and match decision (one extra bit so the +1 and the
    // absolute difference never wrap)
    // ------------------------------------------------------------------
    logic [CNT_W:0]   w_meas;
    logic [CNT_W:0]   w_diff;
    logic             w_match;
    logic [CNT_W-1:0] w_period_new;

    assign w_meas       = {1'b0, r_elapsed} + (CNT_W+1)'(1);
    assign w_diff       = (w_meas >= RATIO_X) ? (w_meas - RATIO_X) : (RATIO_X - w_meas);
    assign w_match      = (w_diff <= TOL_X);
    assign w_period_new = w_meas[CNT_W] ? {CNT_W{1'b1}} : w_meas[CNT_W-1:0];

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    lock_state_t      r_state;
    lock_state_t      w_state_nxt;
    logic [MC_W-1:0]  r_match_cnt;
    logic [MC_W-1:0]  w_match_cnt_nxt;
    logic [MC_W-1:0]  w_cnt_inc;
    logic             w_measure;
    logic             w_timeout;

    logic [CNT_W-1:0] r_period;
    logic             r_period_vld;
    logic             r_locked;
    logic             r_err;
    logic [CNT_W-1:0] w_period_nxt;
    logic             w_period_vld_nxt;
    logic             w_locked_nxt;
    logic             w_err_nxt;

    // The first edge out of IDLE only establishes a reference point.
    assign w_measure = w_edge && (r_state != ST_IDLE);
    assign w_timeout = !w_edge && (r_state != ST_IDLE) && (r_elapsed == TO_LAST);
    assign w_cnt_inc = r_match_cnt + MC_W'(1);

    // State register (outputs are registered alongside the state)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_match_cnt  <= '0;
            r_period     <= '0;
            r_period_vld <= 1'b0;
            r_locked     <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_match_cnt  <= w_match_cnt_nxt;
            r_period     <= w_period_nxt;
            r_period_vld <= w_period_vld_nxt;
            r_locked     <= w_locked_nxt;
            r_err        <= w_err_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt     = r_state;
        w_match_cnt_nxt = r_match_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_edge) begin
                    w_state_nxt     = ST_ACQ;
                    w_match_cnt_nxt = '0;
                end
            end
            ST_ACQ: begin
                if (w_edge) begin
                    if (w_match) begin
                        if (w_cnt_inc == LOCK_TGT) begin
                            w_state_nxt     = ST_LOCKED;
                            w_match_cnt_nxt = '0;
                        end else begin
                            w_match_cnt_nxt = w_cnt_inc;
                        end
                    end else begin
                        w_match_cnt_nxt = '0;
                    end
                end else if (w_timeout) begin
                    w_state_nxt     = ST_IDLE;
                    w_match_cnt_nxt = '0;
                end
            end
            ST_LOCKED: begin
                if (w_edge) begin
                    if (!w_match) begin
                        w_state_nxt     = ST_ACQ;
                        w_match_cnt_nxt = '0;
                    end
                end else if (w_timeout) begin
                    w_state_nxt     = ST_IDLE;
                    w_match_cnt_nxt = '0;
                end
            end
            default: begin
                w_state_nxt     = ST_IDLE;
                w_match_cnt_nxt = '0;
            end
        endcase
    end

    // Output logic (values registered on the next clock)
    always_comb begin
        w_period_vld_nxt = w_measure;
        w_period_nxt     = w_measure ? w_period_new : r_period;
        w_err_nxt        = (w_measure && !w_match) || w_timeout;
        w_locked_nxt     = (w_state_nxt == ST_LOCKED);
    end

    assign period     = r_period;
    assign period_vld = r_period_vld;
    assign locked     = r_locked;
    assign err        = r_err;

endmodule

// File: tb/tb_div_lock_det.sv
// Directed self-checking bench for div_lock_det.
// Instance u_a uses defaults; u_b uses TOL=1 for the tolerance scenario.
module tb_div_lock_det;
    import fmdll_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       div_a;
    logic       div_b;
    logic [7:0] per_a, per_b;
    logic       vld_a, vld_b;
    logic       lock_a, lock_b;
    logic       err_a, err_b;

    always #5 clk = ~clk;

    div_lock_det u_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .div_in     (div_a),
        .period     (per_a),
        .period_vld (vld_a),
        .locked     (lock_a),
        .err        (err_a)
    );

    div_lock_det #(.TOL(1)) u_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .div_in     (div_b),
        .period     (per_b),
        .period_vld (vld_b),
        .locked     (lock_b),
        .err        (err_b)
    );

    int n_chk  = 0;
    int n_fail = 0;

    int cyc = 0;
    int rise_cyc = 0;
    int vld_cnt[2]       = '{0, 0};
    int err_cnt[2]       = '{0, 0};
    int errnv_cnt[2]     = '{0, 0};
    int bad_cnt[2]       = '{0, 0};
    int lock_rise_vld[2] = '{0, 0};
    int lock_rise_cnt[2] = '{0, 0};
    int lock_lost[2]     = '{0, 0};
    int last_err_cyc[2]  = '{0, 0};
    int err_period[2]    = '{0, 0};
    int exp_per[2]       = '{0, 0};
    logic prev_lock[2]   = '{1'b0, 1'b0};

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic sample(input int k, input logic v, input logic e, input logic l,
                          input logic [7:0] p);
        if (v) begin
            vld_cnt[k]++;
            if (exp_per[k] != 0 && int'(p) != exp_per[k]) bad_cnt[k]++;
        end
        if (e) begin
            err_cnt[k]++;
            err_period[k]   = int'(p);
            last_err_cyc[k] = cyc;
            if (!v) errnv_cnt[k]++;
        end
        if (l && !prev_lock[k]) begin
            lock_rise_vld[k] = vld_cnt[k];
            lock_rise_cnt[k]++;
        end
        if (!l && prev_lock[k]) lock_lost[k]++;
        prev_lock[k] = l;
    endtask

    // One clk cycle: observe both DUTs on the falling edge, then drive the selected div_in.
    task automatic tick(input int sel, input logic d);
        @(negedge clk);
        cyc++;
        sample(0, vld_a, err_a, lock_a, per_a);
        sample(1, vld_b, err_b, lock_b, per_b);
        if (sel == 0) div_a = d;
        else          div_b = d;
    endtask

    // One divided-clock period of p cycles starting with a rising edge.
    task automatic send_period(input int sel, input int p);
        int hi;
        hi = (p / 2 < 1) ? 1 : p / 2;
        for (int i = 0; i < p; i++) begin
            tick(sel, (i < hi));
            if (i == 0) rise_cyc = cyc;
        end
    endtask

    int base_v, base_e, base_nv, base_lr;

    initial begin
        rst_n = 1'b1;
        div_a = 1'b0;
        div_b = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_period", per_a, 0);
        chk("rst_period_vld", vld_a, 0);
        chk("rst_locked", lock_a, 0);
        chk("rst_err", err_a, 0);
        chk("rst_state", int'(u_a.r_state), int'(ST_IDLE));
        repeat (3) tick(0, 1'b0);
        rst_n = 1'b1;
        repeat (2) tick(0, 1'b0);

        // Clean /4 input: 10 edges -> 9 measurements, lock on the 8th.
        exp_per[0] = 4;
        repeat (10) send_period(0, 4);
        chk("div4_vld_cnt", vld_cnt[0], 9);
        chk("div4_bad_period", bad_cnt[0], 0);
        chk("div4_lock_at", lock_rise_vld[0], 8);
        chk("div4_err_cnt", err_cnt[0], 0);
        chk("div4_locked", lock_a, 1);
        chk("div4_period", per_a, 4);

        // One short period while locked -> drop lock, relock after 8 good periods.
        base_v = vld_cnt[0];
        base_e = err_cnt[0];
        exp_per[0] = 0;
        send_period(0, 3);
        repeat (9) send_period(0, 4);
        chk("glitch_err_cnt", err_cnt[0] - base_e, 1);
        chk("glitch_err_period", err_period[0], 3);
        chk("glitch_lock_lost", lock_lost[0], 1);
        chk("glitch_relock_at", lock_rise_vld[0] - base_v, 10);
        chk("glitch_locked", lock_a, 1);

        // div_in stops while locked -> single timeout err.
        base_e = err_cnt[0];
        repeat (14) tick(0, 1'b0);
        chk("timeout_err_cnt", err_cnt[0] - base_e, 1);
        chk("timeout_err_delay", last_err_cyc[0] - rise_cyc, 10);
        chk("timeout_locked", lock_a, 0);
        chk("timeout_state", int'(u_a.r_state), int'(ST_IDLE));
        chk("timeout_period_held", per_a, 4);

        // Period 6: every measurement is 6 and errs, never locks.
        base_v  = vld_cnt[0];
        base_e  = err_cnt[0];
        base_nv = errnv_cnt[0];
        base_lr = lock_rise_cnt[0];
        exp_per[0] = 6;
        repeat (6) send_period(0, 6);
        chk("p6_vld_cnt", vld_cnt[0] - base_v, 5);
        chk("p6_err_cnt", err_cnt[0] - base_e, 5);
        chk("p6_err_without_vld", errnv_cnt[0] - base_nv, 0);
        chk("p6_bad_period", bad_cnt[0], 0);
        chk("p6_lock_rises", lock_rise_cnt[0] - base_lr, 0);
        chk("p6_locked", lock_a, 0);

        // Reset while in ACQ with 5 matches.
        exp_per[0] = 4;
        repeat (12) tick(0, 1'b0);
        repeat (6) send_period(0, 4);
        chk("acq_state", int'(u_a.r_state), int'(ST_ACQ));
        chk("acq_match_cnt", int'(u_a.r_match_cnt), 5);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_period", per_a, 0);
        chk("mid_rst_locked", lock_a, 0);
        chk("mid_rst_err", err_a, 0);
        chk("mid_rst_vld", vld_a, 0);
        chk("mid_rst_state", int'(u_a.r_state), int'(ST_IDLE));
        chk("mid_rst_match_cnt", int'(u_a.r_match_cnt), 0);
        repeat (2) tick(0, 1'b0);
        rst_n = 1'b1;
        tick(0, 1'b0);
        base_v = vld_cnt[0];
        repeat (10) send_period(0, 4);
        chk("post_rst_lock_at", lock_rise_vld[0] - base_v, 8);
        chk("post_rst_locked", lock_a, 1);

        // Edge landing exactly on the timeout threshold is a measurement, not a timeout.
        base_v = vld_cnt[0];
        base_e = err_cnt[0];
        exp_per[0] = 0;
        send_period(0, 8);
        send_period(0, 4);
        chk("coinc_err_cnt", err_cnt[0] - base_e, 1);
        chk("coinc_vld_cnt", vld_cnt[0] - base_v, 2);
        chk("coinc_err_period", err_period[0], 8);
        chk("coinc_state", int'(u_a.r_state), int'(ST_ACQ));

        // TOL=1 instance: alternating 3/5 all match.
        repeat (4) begin
            send_period(1, 3);
            send_period(1, 5);
        end
        send_period(1, 3);
        chk("tol_vld_cnt", vld_cnt[1], 8);
        chk("tol_err_cnt", err_cnt[1], 0);
        chk("tol_lock_at", lock_rise_vld[1], 8);
        chk("tol_locked", lock_b, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/div_lock_det.md
DIV_LOCK_DET -- requirements
Module: div_lock_det

Interface
REQ-001 SHALL have parameter DIV_RATIO, default 4, meaning expected divided-clock period in clk cycles (>=2).
REQ-002 SHALL have parameter LOCK_CNT, default 8, meaning consecutive matching periods required to lock.
REQ-003 SHALL have parameter TOL, default 0, meaning allowed |period - DIV_RATIO| deviation.
REQ-004 SHALL have parameter CNT_W, default 8, meaning width of period counter and period output.
REQ-005 SHALL have port clk, input, 1 bit: clock.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port div_in, input, 1 bit: divided clock from a frequency divider.
REQ-008 SHALL have port period, output, CNT_W bits: last measured period in clk cycles.
REQ-009 SHALL have port period_vld, output, 1 bit: one-cycle pulse when period updates.
REQ-010 SHALL have port locked, output, 1 bit: frequency lock indication.
REQ-011 SHALL have port err, output, 1 bit: one-cycle pulse on mismatch or timeout.

Function
REQ-012 SHALL detect a rising edge when the current registered div_in sample is 1 and the previous sample is 0.
REQ-013 SHALL hold an elapsed counter, cleared on each edge cycle and incremented otherwise, saturating at all-ones.
REQ-014 SHALL on every edge except the first after IDLE load period with elapsed+1 and pulse period_vld on the following cycle.
REQ-015 SHALL treat a measurement as matching when |period - DIV_RATIO| <= TOL, using CNT_W+1-bit unsigned arithmetic.
REQ-016 SHALL implement states IDLE, ACQ, LOCKED; all outputs registered.
REQ-017 IDLE: first edge -> ACQ, match count 0, no measurement, no err.
REQ-018 ACQ: match increments match count; on reaching LOCK_CNT -> LOCKED, locked=1 on the same cycle as that period_vld.
REQ-019 ACQ: mismatch clears match count, stays ACQ, pulses err with period_vld.
REQ-020 LOCKED: match keeps state; mismatch pulses err, locked=0, -> ACQ with match count 0.
REQ-021 Timeout: in ACQ or LOCKED, elapsed reaching 2*DIV_RATIO+TOL without an edge -> IDLE, locked=0, err pulse once.
REQ-022 Edge coincident with timeout threshold SHALL be treated as an edge (no timeout).
REQ-023 period SHALL hold its last value between measurements and across timeouts.

Reset
REQ-024 rst_n low SHALL asynchronously force IDLE, period=0, period_vld=0, locked=0, err=0, counters and edge/sync registers 0.
REQ-025 Reset released mid-measurement SHALL restart from IDLE; first post-reset edge produces no measurement.

Configuration
REQ-026 With DIV_LOCK_DET_SYNC_EN defined, div_in SHALL pass through a 2-flop synchronizer before edge detection, adding 2 cycles latency to all responses.
REQ-027 Without DIV_LOCK_DET_SYNC_EN, div_in SHALL be sampled by a single register (source synchronous to clk).

Structure
REQ-028 State encoding typedef (IDLE/ACQ/LOCKED) SHALL live in shared package fmdll_pkg.
REQ-029 Synchronizer SHALL be sub-module sync_2ff, instantiated only under DIV_LOCK_DET_SYNC_EN.
REQ-030 Edge detect, counters and FSM SHALL reside in div_lock_det.

Verification
REQ-031 div_in from a /4 divider on clk, defaults -> period=4 on every period_vld; locked rises with the 8th measurement (9th edge); err never pulses.
REQ-032 div_in with period 6, defaults -> every measurement period=6 with err pulse; locked stays 0.
REQ-033 Locked, then div_in held constant -> 8 cycles after last edge: err one pulse, locked=0, state IDLE; period still 4.
REQ-034 Locked, one period of 3 injected -> err pulse, locked=0; relock after 8 further periods of 4.
REQ-035 TOL=1, periods alternating 3/5 -> no err, lock after 8 measurements.
REQ-036 rst_n asserted in ACQ after 5 matches -> all outputs 0 immediately; after release, lock requires 9 edges again.
